synth_tick_gen: RTL and testbench

SYNTH_TICK_GEN -- requirements
Module: synth_tick_gen

---
 rtl/synth_pkg.sv | 40 ++++
 rtl/synth_slot_seq.sv | 102 ++++++++++
 rtl/synth_tick_gen.sv | 144 ++++++++++++++
 tb/tb_synth_tick_gen.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared definitions for the synth tick generator.
//   aud_mode_e   : serial audio framing (I2S for two channels, TDM above that)
//   RATE_SEL_*   : iRATE_SEL codes
//   seq_state_e  : slot sequencer states
//   clog2w()     : index width helper, never narrower than one bit
//   inc_calc()   : rounded phase increment for a given sample rate
package synth_pkg;

    typedef enum logic {
        MODE_I2S = 1'b0,
        MODE_TDM = 1'b1
    } aud_mode_e;

    localparam logic [1:0] RATE_SEL_0    = 2'd0;
    localparam logic [1:0] RATE_SEL_1    = 2'd1;
    localparam logic [1:0] RATE_SEL_2    = 2'd2;
    localparam logic [1:0] RATE_SEL_RSVD = 2'd3;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_RUN  = 1'b1
    } seq_state_e;

    function automatic int clog2w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // round(2^acc_w * 2*fs*dw*ch / f_clk); the factor of 2 is because the
    // accumulator carry produces one BCK edge, not one BCK period.
    function automatic longint unsigned inc_calc(input int acc_w,
                                                 input longint unsigned fs,
                                                 input int dw,
                                                 input int ch,
                                                 input longint unsigned f_clk);
        longint unsigned num;
        num = (64'd1 << acc_w) * (64'd2 * fs * longint'(dw) * longint'(ch));
        return (num + f_clk / 64'd2) / f_clk;
    endfunction

endpackage

// File: rtl/synth_slot_seq.sv
// Slot sweep sequencer: on start, issues NUM_SLOTS one-cycle enables,
// SPACING clocks apart, first one registered together with start's effect.
// Address order is idx fastest, then voice, beginning at 0/0.
//   clk, rst : clock, synchronous active-high reset
//   start    : one-cycle request to (re)start the sweep at slot 0
//   en       : one-cycle slot enable
//   voice    : outer slot address (held between enables)
//   idx      : inner slot address (held between enables)
//   overrun  : sticky, start arrived before the previous sweep completed
//
// state    | meaning
// SEQ_IDLE | no sweep in progress, last enable already issued
// SEQ_RUN  | sweep in progress, at least one enable still to come
module synth_slot_seq
    import synth_pkg::*;
#(
    parameter int NUM_SLOTS = 32,
    parameter int INNER     = 4,
    parameter int SPACING   = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    output logic                                  en,
    output logic [clog2w(NUM_SLOTS/INNER)-1:0]    voice,
    output logic [clog2w(INNER)-1:0]              idx,
    output logic                                  overrun
);

    localparam int VW = clog2w(NUM_SLOTS / INNER);
    localparam int IW = clog2w(INNER);
    localparam int CW = clog2w(SPACING);
    localparam logic [CW-1:0] CNT_LAST = CW'(SPACING - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(NUM_SLOTS / INNER - 1);
    localparam logic [IW-1:0] I_LAST   = IW'(INNER - 1);
    localparam seq_state_e START_STATE = (NUM_SLOTS > 1) ? SEQ_RUN : SEQ_IDLE;

    seq_state_e    state_q, state_d;
    logic [VW-1:0] voice_q, voice_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          en_q, en_d;
    logic          ovr_q, ovr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEQ_IDLE;
            voice_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            voice_q <= voice_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        voice_d = voice_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        en_d    = 1'b0;
        ovr_d   = ovr_q;
        if (start) begin
            // A start while enables are still owed abandons them.
            ovr_d   = ovr_q | (state_q == SEQ_RUN);
            en_d    = 1'b1;
            voice_d = '0;
            idx_d   = '0;
            cnt_d   = CNT_LAST;
            state_d = START_STATE;
        end else if (state_q == SEQ_RUN) begin
            if (cnt_q == '0) begin
                en_d  = 1'b1;
                cnt_d = CNT_LAST;
                if (idx_q == I_LAST) begin
                    idx_d   = '0;
                    voice_d = voice_q + VW'(1);
                end else begin
                    idx_d = idx_q + IW'(1);
                end
                if (voice_d == V_LAST && idx_d == I_LAST) begin
                    state_d = SEQ_IDLE;
                end
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    assign en      = en_q;
    assign voice   = voice_q;
    assign idx     = idx_q;
    assign overrun = ovr_q;

endmodule

// File: rtl/synth_tick_gen.sv
// Synth timing generator: derives codec BCK/LRCK from a phase accumulator on
// OSC_CLK, marks frame starts, and launches oscillator and envelope slot sweeps
// once per frame.
//   OSC_CLK               : sole clock
//   iRST                  : synchronous active-high reset
//   iRATE_SEL             : sample-rate select, taken at frame start
//   oAUD_BCK, oAUD_LRCK   : codec bit clock and word select / frame sync
//   oCHAN_IDX             : current channel slot
//   oFRAME_TICK           : one-cycle frame-start pulse
//   oOSC_EN/VOICE/IDX     : oscillator slot enable and address
//   oENV_EN/VOICE/IDX     : envelope slot enable and address
//   oOVERRUN              : sticky sweep overrun flag
module synth_tick_gen
    import synth_pkg::*;
#(
    parameter int VOICES      = 8,
    parameter int V_OSC       = 4,
    parameter int V_ENVS      = 2 * V_OSC,
    parameter int DATA_WIDTH  = 16,
    parameter int CHANNEL_NUM = 2,
    parameter int ACC_W       = 32,
    parameter logic [ACC_W-1:0] INC0 =
        ACC_W'(inc_calc(ACC_W, 64'd44100, DATA_WIDTH, CHANNEL_NUM, 64'd180555556)),
    parameter logic [ACC_W-1:0] INC1 =
        ACC_W'(inc_calc(ACC_W, 64'd48000, DATA_WIDTH, CHANNEL_NUM, 64'd180555556)),
    parameter logic [ACC_W-1:0] INC2 =
        ACC_W'(inc_calc(ACC_W, 64'd96000, DATA_WIDTH, CHANNEL_NUM, 64'd180555556)),
    parameter int OSC_SPACING = 16,
    parameter int ENV_SPACING = 8
) (
    input  logic                             OSC_CLK,
    input  logic                             iRST,
    input  logic [1:0]                       iRATE_SEL,
    output logic                             oAUD_BCK,
    output logic                             oAUD_LRCK,
    output logic [clog2w(CHANNEL_NUM)-1:0]   oCHAN_IDX,
    output logic                             oFRAME_TICK,
    output logic                             oOSC_EN,
    output logic [clog2w(VOICES)-1:0]        oOSC_VOICE,
    output logic [clog2w(V_OSC)-1:0]         oOSC_IDX,
    output logic                             oENV_EN,
    output logic [clog2w(VOICES)-1:0]        oENV_VOICE,
    output logic [clog2w(V_ENVS)-1:0]        oENV_IDX,
    output logic                             oOVERRUN
);

    localparam int FRAME_BITS = DATA_WIDTH * CHANNEL_NUM;
    localparam int FB_W       = clog2w(FRAME_BITS);
    localparam int CH_W       = clog2w(CHANNEL_NUM);
    localparam logic [FB_W-1:0] FB_LAST = FB_W'(FRAME_BITS - 1);
    localparam logic [FB_W-1:0] FB_DW   = FB_W'(DATA_WIDTH);
    localparam aud_mode_e MODE = (CHANNEL_NUM > 2) ? MODE_TDM : MODE_I2S;

    logic [ACC_W-1:0] acc_q, inc_q, inc_sel;
    logic [ACC_W:0]   acc_sum;
    logic             carry, bck_fall, wrap;
    logic [FB_W-1:0]  fb_q, fb_d;
    logic [CH_W-1:0]  chan_q, chan_d;
    logic             bck_q, lrck_q, lrck_d;
    logic             wrap_q, tick_q;
    logic             osc_ovr, env_ovr;

    always_comb begin
        acc_sum  = {1'b0, acc_q} + {1'b0, inc_q};
        carry    = acc_sum[ACC_W];
        bck_fall = carry & bck_q;
        wrap     = bck_fall && (fb_q == FB_LAST);
        fb_d     = fb_q;
        if (bck_fall) begin
            fb_d = wrap ? '0 : fb_q + FB_W'(1);
        end
        chan_d = CH_W'(fb_d / FB_DW);
        lrck_d = chan_d[0];
        if (MODE == MODE_TDM) begin
            lrck_d = (fb_d == '0);
        end
        case (iRATE_SEL)
            RATE_SEL_1: inc_sel = INC1;
            RATE_SEL_2: inc_sel = INC2;
            default:    inc_sel = INC0;
        endcase
    end

    // wrap_q marks the FB wrap; the frame tick is the cycle after it, and the
    // sweeps are started from wrap_q so their first enable lines up with it.
    always_ff @(posedge OSC_CLK) begin
        if (iRST) begin
            acc_q  <= '0;
            inc_q  <= INC0;
            bck_q  <= 1'b0;
            fb_q   <= '0;
            chan_q <= '0;
            lrck_q <= 1'b0;
            wrap_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            acc_q  <= acc_sum[ACC_W-1:0];
            bck_q  <= bck_q ^ carry;
            fb_q   <= fb_d;
            chan_q <= chan_d;
            lrck_q <= lrck_d;
            wrap_q <= wrap;
            tick_q <= wrap_q;
            if (tick_q) begin
                inc_q <= inc_sel;
            end
        end
    end

    synth_slot_seq #(
        .NUM_SLOTS (VOICES * V_OSC),
        .INNER     (V_OSC),
        .SPACING   (OSC_SPACING)
    ) u_osc_seq (
        .clk     (OSC_CLK),
        .rst     (iRST),
        .start   (wrap_q),
        .en      (oOSC_EN),
        .voice   (oOSC_VOICE),
        .idx     (oOSC_IDX),
        .overrun (osc_ovr)
    );

    synth_slot_seq #(
        .NUM_SLOTS (VOICES * V_ENVS),
        .INNER     (V_ENVS),
        .SPACING   (ENV_SPACING)
    ) u_env_seq (
        .clk     (OSC_CLK),
        .rst     (iRST),
        .start   (wrap_q),
        .en      (oENV_EN),
        .voice   (oENV_VOICE),
        .idx     (oENV_IDX),
        .overrun (env_ovr)
    );

    assign oAUD_BCK    = bck_q;
    assign oAUD_LRCK   = lrck_q;
    assign oCHAN_IDX   = chan_q;
    assign oFRAME_TICK = tick_q;
    assign oOVERRUN    = osc_ovr | env_ovr;

endmodule

// File: tb/tb_synth_tick_gen.sv
// Directed bench for synth_tick_gen. Three instances share clock and reset:
// the reference I2S configuration, one with a too-wide oscillator spacing, and
// a four-channel TDM one. Edge k after reset release is logged in slot k.
module tb_synth_tick_gen;

    typedef struct {
        logic       bck;
        logic       lrck;
        logic [1:0] chan;
        logic       tick;
        logic       oen;
        logic [1:0] ovi;
        logic       een;
        logic [2:0] evi;
        logic       ovr;
    } snap_t;

    typedef struct {
        int         cyc;
        logic       bck;
        logic       lrck;
        logic [1:0] chan;
        logic       tick;
        logic       oen;
        logic [1:0] ovi;
        logic       een;
        logic [2:0] evi;
        logic       ovr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] rate;
    logic [1:0] rate_fixed;

    logic       m_bck, m_lrck, m_chan, m_tick, m_oen, m_ov, m_oi, m_een, m_ev, m_ovr;
    logic [1:0] m_ei;
    logic       o_bck, o_lrck, o_chan, o_tick, o_oen, o_ov, o_oi, o_een, o_ev, o_ovr;
    logic [1:0] o_ei;
    logic       t_bck, t_lrck, t_tick, t_oen, t_ov, t_oi, t_een, t_ev, t_ovr;
    logic [1:0] t_chan, t_ei;

    snap_t m_log[300];
    snap_t o_log[300];
    snap_t t_log[300];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    synth_tick_gen #(
        .VOICES(2), .V_OSC(2), .V_ENVS(4), .DATA_WIDTH(4), .CHANNEL_NUM(2),
        .ACC_W(8), .INC0(8'd64), .INC1(8'd128), .INC2(8'd192),
        .OSC_SPACING(4), .ENV_SPACING(2)
    ) u_main (
        .OSC_CLK(clk), .iRST(rst), .iRATE_SEL(rate),
        .oAUD_BCK(m_bck), .oAUD_LRCK(m_lrck), .oCHAN_IDX(m_chan),
        .oFRAME_TICK(m_tick), .oOSC_EN(m_oen), .oOSC_VOICE(m_ov), .oOSC_IDX(m_oi),
        .oENV_EN(m_een), .oENV_VOICE(m_ev), .oENV_IDX(m_ei), .oOVERRUN(m_ovr)
    );

    // Last of four enables would come 3*24 = 72 clocks after a tick, beyond
    // the next tick 64 clocks later.
    synth_tick_gen #(
        .VOICES(2), .V_OSC(2), .V_ENVS(4), .DATA_WIDTH(4), .CHANNEL_NUM(2),
        .ACC_W(8), .INC0(8'd64), .INC1(8'd128), .INC2(8'd192),
        .OSC_SPACING(24), .ENV_SPACING(2)
    ) u_ovr (
        .OSC_CLK(clk), .iRST(rst), .iRATE_SEL(rate_fixed),
        .oAUD_BCK(o_bck), .oAUD_LRCK(o_lrck), .oCHAN_IDX(o_chan),
        .oFRAME_TICK(o_tick), .oOSC_EN(o_oen), .oOSC_VOICE(o_ov), .oOSC_IDX(o_oi),
        .oENV_EN(o_een), .oENV_VOICE(o_ev), .oENV_IDX(o_ei), .oOVERRUN(o_ovr)
    );

    synth_tick_gen #(
        .VOICES(2), .V_OSC(2), .V_ENVS(4), .DATA_WIDTH(4), .CHANNEL_NUM(4),
        .ACC_W(8), .INC0(8'd64), .INC1(8'd128), .INC2(8'd192),
        .OSC_SPACING(4), .ENV_SPACING(2)
    ) u_tdm (
        .OSC_CLK(clk), .iRST(rst), .iRATE_SEL(rate_fixed),
        .oAUD_BCK(t_bck), .oAUD_LRCK(t_lrck), .oCHAN_IDX(t_chan),
        .oFRAME_TICK(t_tick), .oOSC_EN(t_oen), .oOSC_VOICE(t_ov), .oOSC_IDX(t_oi),
        .oENV_EN(t_een), .oENV_VOICE(t_ev), .oENV_IDX(t_ei), .oOVERRUN(t_ovr)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step_log(input int k);
        @(posedge clk);
        @(negedge clk);
        m_log[k] = '{m_bck, m_lrck, {1'b0, m_chan}, m_tick, m_oen, {m_ov, m_oi},
                     m_een, {m_ev, m_ei}, m_ovr};
        o_log[k] = '{o_bck, o_lrck, {1'b0, o_chan}, o_tick, o_oen, {o_ov, o_oi},
                     o_een, {o_ev, o_ei}, o_ovr};
        t_log[k] = '{t_bck, t_lrck, t_chan, t_tick, t_oen, {t_ov, t_oi},
                     t_een, {t_ev, t_ei}, t_ovr};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bck"},  m_bck,  0);
        chk({tag, "_lrck"}, m_lrck, 0);
        chk({tag, "_chan"}, m_chan, 0);
        chk({tag, "_tick"}, m_tick, 0);
        chk({tag, "_oen"},  m_oen,  0);
        chk({tag, "_oaddr"}, {m_ov, m_oi}, 0);
        chk({tag, "_een"},  m_een,  0);
        chk({tag, "_eaddr"}, {m_ev, m_ei}, 0);
        chk({tag, "_ovr"},  m_ovr,  0);
    endtask

    vec_t vecs[20];

    initial begin
        int cnt;
        // cyc  bck lrck chan tick oen ovi   een evi    ovr
        vecs[0]  = '{3,   0, 0, 2'd0, 0, 0, 2'b00, 0, 3'b000, 0};
        vecs[1]  = '{4,   1, 0, 2'd0, 0, 0, 2'b00, 0, 3'b000, 0};
        vecs[2]  = '{8,   0, 0, 2'd0, 0, 0, 2'b00, 0, 3'b000, 0};
        vecs[3]  = '{31,  1, 0, 2'd0, 0, 0, 2'b00, 0, 3'b000, 0};
        vecs[4]  = '{32,  0, 1, 2'd1, 0, 0, 2'b00, 0, 3'b000, 0};
        vecs[5]  = '{64,  0, 0, 2'd0, 0, 0, 2'b00, 0, 3'b000, 0};
        vecs[6]  = '{65,  0, 0, 2'd0, 1, 1, 2'b00, 1, 3'b000, 0};
        vecs[7]  = '{66,  0, 0, 2'd0, 0, 0, 2'b00, 0, 3'b000, 0};
        vecs[8]  = '{67,  0, 0, 2'd0, 0, 0, 2'b00, 1, 3'b001, 0};
        vecs[9]  = '{69,  1, 0, 2'd0, 0, 1, 2'b01, 1, 3'b010, 0};
        vecs[10] = '{70,  1, 0, 2'd0, 0, 0, 2'b01, 0, 3'b010, 0};
        vecs[11] = '{73,  0, 0, 2'd0, 0, 1, 2'b10, 1, 3'b100, 0};
        vecs[12] = '{77,  1, 0, 2'd0, 0, 1, 2'b11, 1, 3'b110, 0};
        vecs[13] = '{79,  1, 0, 2'd0, 0, 0, 2'b11, 1, 3'b111, 0};
        vecs[14] = '{81,  0, 0, 2'd0, 0, 0, 2'b11, 0, 3'b111, 0};
        vecs[15] = '{96,  0, 1, 2'd1, 0, 0, 2'b11, 0, 3'b111, 0};
        vecs[16] = '{128, 0, 0, 2'd0, 0, 0, 2'b11, 0, 3'b111, 0};
        vecs[17] = '{129, 0, 0, 2'd0, 1, 1, 2'b00, 1, 3'b000, 0};
        vecs[18] = '{130, 0, 0, 2'd0, 0, 0, 2'b00, 0, 3'b000, 0};
        vecs[19] = '{200, 0, 0, 2'd0, 0, 0, 2'b01, 0, 3'b011, 0};

        rate       = 2'd0;
        rate_fixed = 2'd0;

        // ---- Run 1: fixed rate, all three instances ----
        do_reset();
        chk_all_zero("rst");
        rst = 1'b0;
        for (int k = 1; k <= 260; k++) step_log(k);

        foreach (vecs[i]) begin
            snap_t s;
            s = m_log[vecs[i].cyc];
            chk($sformatf("bck@%0d", vecs[i].cyc),  s.bck,  vecs[i].bck);
            chk($sformatf("lrck@%0d", vecs[i].cyc), s.lrck, vecs[i].lrck);
            chk($sformatf("chan@%0d", vecs[i].cyc), s.chan, vecs[i].chan);
            chk($sformatf("tick@%0d", vecs[i].cyc), s.tick, vecs[i].tick);
            chk($sformatf("oen@%0d", vecs[i].cyc),  s.oen,  vecs[i].oen);
            chk($sformatf("oaddr@%0d", vecs[i].cyc), s.ovi, vecs[i].ovi);
            chk($sformatf("een@%0d", vecs[i].cyc),  s.een,  vecs[i].een);
            chk($sformatf("eaddr@%0d", vecs[i].cyc), s.evi, vecs[i].evi);
            chk($sformatf("ovr@%0d", vecs[i].cyc),  s.ovr,  vecs[i].ovr);
        end

        cnt = 0;
        for (int k = 1; k <= 200; k++) if (m_log[k].tick) cnt++;
        chk("main_tick_count", cnt, 3);
        cnt = 0;
        for (int k = 65; k <= 128; k++) if (m_log[k].oen) cnt++;
        chk("main_osc_pulses", cnt, 4);
        cnt = 0;
        for (int k = 65; k <= 128; k++) if (m_log[k].een) cnt++;
        chk("main_env_pulses", cnt, 8);

        // overrun instance
        chk("ovr_en@89",    o_log[89].oen, 1);
        chk("ovr_addr@113", o_log[113].ovi, 2'b10);
        chk("ovr_flag@128", o_log[128].ovr, 0);
        chk("ovr_flag@129", o_log[129].ovr, 1);
        chk("ovr_en@129",   o_log[129].oen, 1);
        chk("ovr_addr@129", o_log[129].ovi, 2'b00);
        chk("ovr_en@137",   o_log[137].oen, 0);
        chk("ovr_en@153",   o_log[153].oen, 1);
        chk("ovr_addr@153", o_log[153].ovi, 2'b01);
        chk("ovr_sticky@260", o_log[260].ovr, 1);

        // TDM instance: 128-clock frame, wrap at edge 128
        cnt = 0;
        for (int k = 128; k <= 255; k++) if (t_log[k].lrck) cnt++;
        chk("tdm_lrck_high", cnt, 8);
        chk("tdm_lrck@135", t_log[135].lrck, 1);
        chk("tdm_lrck@136", t_log[136].lrck, 0);
        chk("tdm_tick@129", t_log[129].tick, 1);
        chk("tdm_chan@140", t_log[140].chan, 0);
        chk("tdm_chan@170", t_log[170].chan, 1);
        chk("tdm_chan@200", t_log[200].chan, 2);
        chk("tdm_chan@230", t_log[230].chan, 3);

        // ---- Run 2: rate change mid-frame takes effect only at the tick ----
        do_reset();
        rst = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            step_log(k);
            if (k == 20) rate = 2'd1;
        end
        chk("rate_bck@23", m_log[23].bck ^ m_log[20].bck, 0);
        chk("rate_bck@24", m_log[24].bck ^ m_log[23].bck, 1);
        chk("rate_tick@65", m_log[65].tick, 1);
        chk("rate_bck@65", m_log[65].bck ^ m_log[64].bck, 0);
        chk("rate_bck@66", m_log[66].bck ^ m_log[65].bck, 0);
        chk("rate_bck@67", m_log[67].bck ^ m_log[66].bck, 1);
        chk("rate_bck@100", m_log[100].bck ^ m_log[99].bck, 0);
        chk("rate_bck@101", m_log[101].bck ^ m_log[100].bck, 1);
        chk("rate_tick@98",  m_log[98].tick, 1);
        chk("rate_tick@130", m_log[130].tick, 1);
        chk("rate_tick@162", m_log[162].tick, 1);
        cnt = 0;
        for (int k = 1; k <= 170; k++) if (m_log[k].tick) cnt++;
        chk("rate_tick_count", cnt, 4);
        rate = 2'd0;

        // ---- Run 3: one-clock reset in the middle of a sweep ----
        do_reset();
        rst = 1'b0;
        for (int k = 1; k <= 69; k++) step_log(k);
        chk("mid_sweep_en@69", m_log[69].oen, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("midrst");
        rst = 1'b0;
        for (int k = 1; k <= 70; k++) step_log(k);
        cnt = 0;
        for (int k = 1; k <= 64; k++) if (m_log[k].oen || m_log[k].een || m_log[k].tick) cnt++;
        chk("midrst_no_pending", cnt, 0);
        chk("midrst_tick@64", m_log[64].tick, 0);
        chk("midrst_tick@65", m_log[65].tick, 1);
        chk("midrst_oen@65",  m_log[65].oen, 1);
        chk("midrst_oaddr@65", m_log[65].ovi, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
